// File: rtl/switch_debounce_ctrl.sv
// Avalon-MM slide-switch sampler: 2-flop sync, tick-paced debounce, edge capture, maskable irq.
// Define SWITCH_DEBOUNCE_BOTH_EDGE_EN to capture falling as well as rising debounced edges.
`timescale 1ns/1ps
module switch_debounce_ctrl #(
    parameter int WIDTH        = 3,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int              CNT_W       = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       STABLE_LAST = 4'(STABLE_TICKS);

    typedef enum logic {ST_STABLE, ST_CHANGING} db_state_e;

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [WIDTH-1:0] ec_q, ec_d, mask_q, mask_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             enable_q, enable_d, irq_q, irq_d;
    logic [31:0]      readdata_q, readdata_d;
    db_state_e        state_q [WIDTH];
    db_state_e        state_d [WIDTH];
    logic [3:0]       count_q [WIDTH];
    logic [3:0]       count_d [WIDTH];
    logic             tick, wr_en;
    logic [WIDTH-1:0] edge_det;

    // The read strobe never gates the register mux, so it has no load.
    logic unused_inputs;
    assign unused_inputs = read;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        sync1_d    = in_port;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        wr_en      = chipselect & write;

        tick       = enable_q && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (enable_q) tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            if (tick) begin
                if (state_q[i] == ST_STABLE) begin
                    if (sync2_q[i] != deb_q[i]) begin
                        if (STABLE_TICKS == 1) begin
                            deb_d[i] = ~deb_q[i];
                        end else begin
                            state_d[i] = ST_CHANGING;
                            count_d[i] = 4'd1;
                        end
                    end
                end else if (sync2_q[i] == deb_q[i]) begin
                    state_d[i] = ST_STABLE;
                    count_d[i] = 4'd0;
                end else if (count_q[i] + 4'd1 == STABLE_LAST) begin
                    deb_d[i]   = ~deb_q[i];
                    state_d[i] = ST_STABLE;
                    count_d[i] = 4'd0;
                end else begin
                    count_d[i] = count_q[i] + 4'd1;
                end
            end
        end

`ifdef SWITCH_DEBOUNCE_BOTH_EDGE_EN
        edge_det = deb_q ^ deb_prev_q;
`else
        edge_det = deb_q & ~deb_prev_q;
`endif
        // Clear first, then set, so a capture landing with a W1C write survives.
        ec_d = ec_q;
        if (wr_en && address == 2'd2) ec_d = ec_q & ~writedata[WIDTH-1:0];
        ec_d = ec_d | edge_det;

        mask_d   = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
        enable_d = (wr_en && address == 2'd3) ? writedata[0] : enable_q;
        irq_d    = |(ec_q & mask_q);

        readdata_d = '0;
        case (address)
            2'd0: readdata_d = 32'(deb_q);
            2'd1: readdata_d = 32'(mask_q);
            2'd2: readdata_d = 32'(ec_q);
            2'd3: readdata_d = {31'b0, enable_q};
            default: readdata_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the per-bit arrays are reset too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            ec_q       <= '0;
            mask_q     <= '0;
            tick_cnt_q <= '0;
            enable_q   <= 1'b1;
            irq_q      <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                count_q[i] <= 4'd0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            ec_q       <= ec_d;
            mask_q     <= mask_d;
            tick_cnt_q <= tick_cnt_d;
            enable_q   <= enable_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Scoreboard bench for switch_debounce_ctrl: random switch/bus traffic against a run-length reference model.
`timescale 1ns/1ps
module tb_switch_debounce_ctrl;
    localparam int WIDTH        = 3;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             read = 1'b0;
    logic             write = 1'b0;
    logic [31:0]      writedata = '0;
    logic [WIDTH-1:0] in_port = '1;
    logic [31:0]      readdata;
    logic             irq;

    always #5 clk = ~clk;

    switch_debounce_ctrl #(
        .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic        irq;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    // Reference model: switch value seen after two clocks, a bit flips once it has differed
    // from the debounced value on STABLE_TICKS consecutive ticks.
    logic [WIDTH-1:0] m_sync1, m_sync2, m_deb, m_deb_prev, m_ec, m_mask;
    logic             m_en, m_irq;
    int               m_cnt;
    int               m_run [WIDTH];
    logic             resp_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = '0; m_sync2 = '0; m_deb = '0; m_deb_prev = '0;
        m_ec = '0; m_mask = '0; m_en = 1'b1; m_irq = 1'b0; m_cnt = 0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        resp_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] n_deb, changed, n_ec;
        logic [31:0]      n_rd;
        logic             tick, wr;
        tick = m_en && (m_cnt == TICK_DIV - 1);
        wr   = chipselect && write;
        case (address)
            2'd0:    n_rd = 32'(m_deb);
            2'd1:    n_rd = 32'(m_mask);
            2'd2:    n_rd = 32'(m_ec);
            default: n_rd = {31'b0, m_en};
        endcase
        resp_valid = chipselect && read;
        if (resp_valid) exp_q.push_back('{address, n_rd, |(m_ec & m_mask)});

        n_deb = m_deb;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (m_sync2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STABLE_TICKS) begin
                        n_deb[i] = ~m_deb[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
`ifdef SWITCH_DEBOUNCE_BOTH_EDGE_EN
        changed = m_deb ^ m_deb_prev;
`else
        changed = m_deb & ~m_deb_prev;
`endif
        n_ec = m_ec;
        if (wr && address == 2'd2) n_ec = n_ec & ~writedata[WIDTH-1:0];
        n_ec = n_ec | changed;

        m_irq = |(m_ec & m_mask);
        if (m_en) m_cnt = (m_cnt + 1) % TICK_DIV;
        if (wr && address == 2'd1) m_mask = writedata[WIDTH-1:0];
        if (wr && address == 2'd3) m_en = writedata[0];
        m_ec       = n_ec;
        m_deb_prev = m_deb;
        m_deb      = n_deb;
        m_sync2    = m_sync1;
        m_sync1    = in_port;
    endtask

    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Monitor: each read response appears on readdata one cycle after the strobe.
    always @(negedge clk) begin
        resp_t r;
        if (reset_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: response with no expected entry at %0t", $time);
            end else begin
                r = exp_q.pop_front();
                check($sformatf("readdata_a%0d", r.addr), readdata, r.rdata);
                check("irq", 32'(irq), 32'(r.irq));
            end
        end
    end

    task automatic run_random(input int n, input int first_hold);
        int hold;
        int r;
        hold = first_hold;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chipselect = 1'b0; read = 1'b0; write = 1'b0;
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if (hold == 0) begin
                in_port[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
                hold = $urandom_range(1, 60);
            end else begin
                hold--;
            end
            r = $urandom_range(0, 99);
            if ((m_deb ^ m_deb_prev) != '0 && r < 50) begin
                // Land a W1C on the very edge where the capture bit is being set.
                chipselect = 1'b1; write = 1'b1; address = 2'd2;
                writedata  = 32'(m_deb ^ m_deb_prev);
            end else if (r < 55) begin
                chipselect = 1'b1; read = 1'b1;
            end else if (r < 70) begin
                chipselect = 1'b1; write = 1'b1;
                if (address == 2'd3) writedata[0] = ($urandom_range(0, 15) != 0);
            end
        end
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        run_random(3000, 40);

        // Reset with switches held high part-way through activity.
        in_port = '1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        run_random(2000, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
